// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: opcodes, funct3 codes, FSM encoding and decode helpers for the MEM stage
package mem_access_unit_pkg;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;
  function automatic logic writes_rd(input logic [6:0] opc);
    return opc inside {OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR};
  endfunction
  function automatic logic f3_load_ok(input logic [2:0] f3);
    return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  endfunction
  function automatic logic f3_store_ok(input logic [2:0] f3);
    return f3 inside {F3_B, F3_H, F3_W};
  endfunction
endpackage

// File: rtl/mem_access_unit_load_align.sv
// mem_access_unit_load_align: picks the addressed byte/half lane of a load word and extends it
module mem_access_unit_load_align
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  assign w_byte = i_rdata[{i_addr, 3'b000} +: 8];
  assign w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];
  always_comb
    o_data = i_funct3 == F3_B  ? {{24{w_byte[7]}}, w_byte} :
             i_funct3 == F3_H  ? {{16{w_half[15]}}, w_half} :
             i_funct3 == F3_BU ? {24'd0, w_byte} :
             i_funct3 == F3_HU ? {16'd0, w_half} : i_rdata;
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: RV32I MEM stage -- req/gnt/rvalid data bus, store lane steering, registered write-back
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] alu_out_i,
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  funct3_i,
  input  logic [4:0]  rd_i,
  input  logic [31:0] rs2_data_i,
  output logic        stall_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic [31:0] wb_data_o,
  output logic [4:0]  rd_o,
  output logic        wb_en_o,
  output logic        misalign_o,
  output logic        bus_err_o
);
  localparam int CW = $clog2(TIMEOUT);
  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_rdata, w_load_val;
  logic          r_err, w_is_load, w_is_store, w_misalign, w_go, w_busy, w_timeout, w_capture;
  assign w_is_load  = opcode_i == OPC_LOAD && f3_load_ok(funct3_i);
  assign w_is_store = opcode_i == OPC_STORE && f3_store_ok(funct3_i);
  assign w_misalign = (w_is_load || w_is_store) &&
                      (funct3_i[1:0] == 2'b01 ? alu_out_i[0] :
                       funct3_i[1:0] == 2'b10 ? |alu_out_i[1:0] : 1'b0);
  assign w_go       = (w_is_load || w_is_store) && !w_misalign;
  assign w_busy     = r_state == S_REQ || r_state == S_WAIT;
  assign w_timeout  = r_cnt == CW'(TIMEOUT - 1);
  assign dmem_addr_o  = {alu_out_i[31:2], 2'b00};
  assign dmem_we_o    = w_is_store;
  assign dmem_be_o    = funct3_i[1:0] == 2'b00 ? 4'b0001 << alu_out_i[1:0] :
                        funct3_i[1:0] == 2'b01 ? 4'b0011 << {alu_out_i[1], 1'b0} : 4'b1111;
  assign dmem_wdata_o = funct3_i[1:0] == 2'b00 ? {4{rs2_data_i[7:0]}} :
                        funct3_i[1:0] == 2'b01 ? {2{rs2_data_i[15:0]}} : rs2_data_i;
  mem_access_unit_load_align u_align (
    .i_rdata  (r_rdata),
    .i_addr   (alu_out_i[1:0]),
    .i_funct3 (funct3_i),
    .o_data   (w_load_val)
  );
  // A completing response always wins over the timeout on the same cycle.
  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    case (r_state)
      S_IDLE: w_next = w_go ? S_REQ : S_IDLE;
      S_REQ: begin
        w_capture = dmem_gnt_i && dmem_rvalid_i;
        w_next    = w_capture || w_timeout ? S_DONE : dmem_gnt_i ? S_WAIT : S_REQ;
      end
      S_WAIT: begin
        w_capture = dmem_rvalid_i;
        w_next    = w_capture || w_timeout ? S_DONE : S_WAIT;
      end
      default: w_next = S_IDLE;
    endcase
    stall_o    = rst_n && (w_busy || (r_state == S_IDLE && w_go));
    dmem_req_o = r_state == S_REQ;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_busy ? r_cnt + CW'(1) : '0;
      if (w_capture) r_rdata <= dmem_rdata_i;
      if (w_busy) r_err <= !w_capture;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wb_data_o  <= '0;
      rd_o       <= '0;
      wb_en_o    <= 1'b0;
      misalign_o <= 1'b0;
      bus_err_o  <= 1'b0;
    end else begin
      misalign_o <= r_state == S_IDLE && w_misalign;
      bus_err_o  <= r_state == S_DONE && r_err;
      wb_en_o    <= r_state == S_IDLE ? writes_rd(opcode_i) && rd_i != 5'd0 :
                    r_state == S_DONE && w_is_load && !r_err && rd_i != 5'd0;
      if (r_state == S_IDLE || r_state == S_DONE) begin
        wb_data_o <= r_state == S_DONE && w_is_load && !r_err ? w_load_val : alu_out_i;
        rd_o      <= rd_i;
      end
    end
endmodule
